imem_loader: RTL



---
 rtl/imem_loader_pkg.sv | 6 +
 rtl/imem_word_packer.sv | 31 +++
 rtl/imem_loader.sv | 79 +++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared loader state encoding and imem geometry
package imem_loader_pkg;
  localparam int IMEM_ADDR_W = 12;
  localparam int INSTR_W = 32;
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR} state_t;
endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: assembles four little-endian bytes into one instruction word
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               byte_en,
  input  logic [7:0]         byte_in,
  output logic [1:0]         byte_idx,
  output logic [INSTR_W-1:0] word,
  output logic               word_valid
);
  logic [23:0] low;
  // shift the first three bytes in from the top, so byte 0 lands in [7:0]; the fourth completes the word
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      byte_idx <= '0;
      low <= '0;
      word <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= byte_en && byte_idx == 2'd3;
      if (clear) byte_idx <= '0;
      else if (byte_en) begin
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) word <= {byte_in, low};
        else low <= {byte_in, low[23:8]};
      end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader writing imem and gating the processor reset
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DEPTH = 4096
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               imem_wEn,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_dataIn,
  output logic               cpu_reset,
  output logic               busy,
  output logic               done,
  output logic               error
);
  localparam logic [15:0] MAXLEN = 16'(DEPTH);
  state_t state, nxt;
  logic [15:0] len, wcnt, len_full;
  logic [7:0] chk;
  logic [1:0] byte_idx;
  logic acc, idle, last_byte;
  assign acc = in_valid && in_ready;
  assign idle = state == IDLE || state == DONE || state == ERR;
  assign len_full = {in_data, len[7:0]};
  assign last_byte = acc && state == DATA && byte_idx == 2'd3;
  imem_word_packer u_packer (
    .clock(clock), .reset(reset), .clear(start && idle), .byte_en(acc && state == DATA),
    .byte_in(in_data), .byte_idx(byte_idx), .word(imem_dataIn), .word_valid(imem_wEn)
  );
  // next state: bytes only move the FSM when actually transferred
  always_comb begin
    nxt = state;
    case (state)
      LEN_LO: nxt = acc ? LEN_HI : state;
      LEN_HI: nxt = !acc ? state : len_full > MAXLEN ? ERR : len_full == 16'd0 ? CHK : DATA;
      DATA: nxt = last_byte && wcnt + 16'd1 == len ? CHK : state;
      CHK: nxt = !acc ? state : in_data == chk ? DONE : ERR;
      default: nxt = start ? LEN_LO : state;
    endcase
  end
  // state, registered status outputs, length/checksum capture and write address
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      in_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      cpu_reset <= 1'b1;
      len <= '0;
      wcnt <= '0;
      chk <= '0;
      imem_addr <= '0;
    end else begin
      state <= nxt;
      in_ready <= nxt inside {LEN_LO, LEN_HI, DATA, CHK};
      busy <= nxt inside {LEN_LO, LEN_HI, DATA, CHK};
      done <= nxt == DONE;
      error <= nxt == ERR;
      cpu_reset <= nxt != DONE;
      if (start && idle) begin
        chk <= '0;
        wcnt <= '0;
      end
      if (acc && state inside {LEN_LO, LEN_HI, DATA}) chk <= chk ^ in_data;
      if (acc && state == LEN_LO) len[7:0] <= in_data;
      if (acc && state == LEN_HI) len[15:8] <= in_data;
      if (last_byte) begin
        wcnt <= wcnt + 16'd1;
        imem_addr <= wcnt[ADDR_W-1:0];
      end
    end
endmodule
